sccb_write_master: RTL and testbench

Byte-level SCCB (OV7670-compatible, I2C-like) write engine for the camera configuration path. It runs on i2c_clk (1 MHz) and sits directly below the camera register-configuration sequencer. The sequencer hands it one {device address, register address, data} triple per request. The engine generates the complete 3-phase SCCB write waveform on the camera SCL/SDA pins, then reports completion and a NACK flag.

---
 rtl/sccb_pkg.sv | 43 ++++
 rtl/sccb_write_master_qtick.sv | 42 ++++
 rtl/sccb_write_master.sv | 175 +++++++++++++++++
 tb/tb_sccb_write_master.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_pkg
//  Description : Shared constants, state encoding and helpers for the SCCB
//                (OV7670-style) three-phase write engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package sccb_pkg;

    // Waveform geometry, all counted in SCL quarter periods
    localparam int QTR_PER_BIT    = 4;
    localparam int BITS_PER_PHASE = 9;
    localparam int PHASES         = 3;
    localparam int START_QTR      = 2;
    localparam int STOP_QTR       = 3;
    localparam int TOTAL_BITS     = BITS_PER_PHASE * PHASES;
    localparam int TOTAL_QTR      = START_QTR + TOTAL_BITS * QTR_PER_BIT + STOP_QTR;

    localparam logic [4:0] LAST_BIT = 5'(TOTAL_BITS - 1);

    // FSM state encoding
    typedef logic [2:0] sccb_state_t;
    localparam sccb_state_t ST_IDLE  = 3'd0;
    localparam sccb_state_t ST_START = 3'd1;
    localparam sccb_state_t ST_BIT   = 3'd2;
    localparam sccb_state_t ST_STOP  = 3'd3;
    localparam sccb_state_t ST_DONE  = 3'd4;

    // The ninth bit of every phase is the don't-care/ack slot.
    function automatic logic is_ack_slot(input logic [4:0] bit_idx);
        return (bit_idx == 5'd8) || (bit_idx == 5'd17) || (bit_idx == 5'd26);
    endfunction

    // Serial frame, MSB first. A '1' means "release SDA", which makes the
    // ack slots fall out of the same shift path as the data bits.
    function automatic logic [26:0] build_frame(input logic [7:0] dev,
                                                input logic [7:0] sub,
                                                input logic [7:0] dat);
        return {dev, 1'b1, sub, 1'b1, dat, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sccb_write_master_qtick.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_qtick
//  Description : Quarter-tick generator. Emits a one-cycle tick every CLK_DIV
//                cycles while en=1; the counter is held at zero while en=0 so
//                the first quarter of a transaction starts on the accept edge.
//  Ports       : i2c_clk  - clock
//                reset_n  - asynchronous active-low reset
//                en       - count enable (engine busy)
//                tick     - one-cycle pulse on the last cycle of each quarter
//  Revision    : 1.0 - initial release
// ============================================================================
module sccb_qtick #(
    parameter int CLK_DIV = 3           // cycles per quarter, minimum 2
) (
    input  logic i2c_clk,
    input  logic reset_n,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i2c_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (!en || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    // en is the registered busy flag, so tick never depends on a port input.
    assign tick = en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/sccb_write_master.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_write_master
//  Description : Byte-level SCCB write engine. Accepts one {device, register,
//                data} triple, emits start, 27 bits (3 x 8 data + ack slot)
//                and stop on SCL/SDA, then pulses done with a sticky NACK flag.
//  Ports       : i2c_clk  - 1 MHz clock
//                reset_n  - asynchronous active-low reset
//                start    - request, accepted when busy=0
//                dev_addr - SCCB write ID          (latched on accept)
//                reg_addr - register sub-address   (latched on accept)
//                reg_data - register write data    (latched on accept)
//                busy     - transaction in progress
//                done     - one-cycle completion pulse
//                ack_err  - some ack slot read high (valid from done)
//                scl      - push-pull SCCB clock, idle high
//                sda_oe   - 1 pulls SDA low, 0 releases it
//                sda_in   - sampled SDA pin level
//  Revision    : 1.0 - initial release
// ============================================================================
module sccb_write_master
    import sccb_pkg::*;
#(
    parameter int CLK_DIV = 3           // i2c_clk cycles per quarter SCL period
) (
    input  logic       i2c_clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] reg_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_in
);

    sccb_state_t  r_state;
    logic [1:0]   r_qidx;       // quarter within the current START/BIT/STOP step
    logic [4:0]   r_bit_cnt;    // 0..26 across all three phases
    logic [26:0]  r_shift;      // remaining frame, MSB is the bit on the wire
    logic         r_busy;
    logic         r_done;
    logic         r_ack_err;
    logic         r_scl;
    logic         r_sda_oe;
    logic         w_tick;

    sccb_qtick #(
        .CLK_DIV (CLK_DIV)
    ) u_qtick (
        .i2c_clk (i2c_clk),
        .reset_n (reset_n),
        .en      (r_busy),
        .tick    (w_tick)
    );

    // Every output changes only on a clock edge; each tick moves the bus to
    // the levels of the quarter that starts on that edge.
    always_ff @(posedge i2c_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_qidx    <= 2'd0;
            r_bit_cnt <= 5'd0;
            r_shift   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_scl     <= 1'b1;
            r_sda_oe  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // DONE shares the accept path with IDLE so a request present
                // during the done pulse starts the next transaction at once.
                ST_IDLE, ST_DONE: begin
                    r_state  <= ST_IDLE;
                    r_scl    <= 1'b1;
                    r_sda_oe <= 1'b0;
                    if (start) begin
                        r_shift   <= build_frame(dev_addr, reg_addr, reg_data);
                        r_ack_err <= 1'b0;
                        r_bit_cnt <= 5'd0;
                        r_qidx    <= 2'd0;
                        r_busy    <= 1'b1;
                        r_sda_oe  <= 1'b1;      // start condition: SDA falls, SCL high
                        r_state   <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_tick) begin
                        if (r_qidx == 2'd0) begin
                            r_scl  <= 1'b0;
                            r_qidx <= 2'd1;
                        end else begin
                            r_qidx   <= 2'd0;
                            r_sda_oe <= ~r_shift[26];
                            r_state  <= ST_BIT;
                        end
                    end
                end

                ST_BIT: begin
                    if (w_tick) begin
                        case (r_qidx)
                            2'd0: r_qidx <= 2'd1;
                            2'd1: begin
                                r_scl  <= 1'b1;
                                r_qidx <= 2'd2;
                            end
                            2'd2: begin
                                // Last cycle of the first SCL-high quarter.
                                if (is_ack_slot(r_bit_cnt) && sda_in) begin
                                    r_ack_err <= 1'b1;
                                end
                                r_qidx <= 2'd3;
                            end
                            default: begin
                                r_scl  <= 1'b0;
                                r_qidx <= 2'd0;
                                if (r_bit_cnt == LAST_BIT) begin
                                    r_sda_oe <= 1'b1;   // hold SDA low ahead of stop
                                    r_state  <= ST_STOP;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + 5'd1;
                                    r_shift   <= {r_shift[25:0], 1'b0};
                                    r_sda_oe  <= ~r_shift[25];
                                end
                            end
                        endcase
                    end
                end

                ST_STOP: begin
                    if (w_tick) begin
                        case (r_qidx)
                            2'd0: begin
                                r_scl  <= 1'b1;
                                r_qidx <= 2'd1;
                            end
                            2'd1: begin
                                r_sda_oe <= 1'b0;       // stop condition: SDA rises, SCL high
                                r_qidx   <= 2'd2;
                            end
                            default: begin
                                r_qidx  <= 2'd0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= ST_DONE;
                            end
                        endcase
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_scl    <= 1'b1;
                    r_sda_oe <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign ack_err = r_ack_err;
    assign scl     = r_scl;
    assign sda_oe  = r_sda_oe;

endmodule
`default_nettype wire

// File: tb/tb_sccb_write_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sccb_write_master
//  Description : Self-checking bench for sccb_write_master. Expected bytes and
//                ack results are queued when a request is driven and consumed
//                by a bus monitor that decodes SDA on SCL rising edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sccb_write_master;

    localparam int DIV1       = 3;
    localparam int DIV2       = 2;
    localparam int QTRS       = 2 + 27 * 4 + 3;
    localparam int EXP_BUSY1  = QTRS * DIV1;
    localparam int EXP_BUSY2  = QTRS * DIV2;

    logic       i2c_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start   = 1'b0;
    logic       start2  = 1'b0;
    logic [7:0] dev_addr = 8'h00;
    logic [7:0] reg_addr = 8'h00;
    logic [7:0] reg_data = 8'h00;
    logic       sda_in2 = 1'b0;
    logic       nack_second = 1'b0;

    logic busy, done, ack_err, scl, sda_oe, sda_in;
    logic busy2, done2, ack_err2, scl2, sda_oe2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_bytes[$];
    logic       exp_ack[$];

    int         mon_nbits  = 0;
    int         starts_seen = 0;
    int         stops_seen  = 0;
    int         dones_seen  = 0;
    int         busy_len    = 0;
    logic [8:0] bitbuf      = '0;
    logic       prev_scl = 1'b1, prev_oe = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;

    always #5 i2c_clk = ~i2c_clk;

    // Slave model: NACK only in the second ack slot when requested.
    assign sda_in = nack_second && (mon_nbits == 18);

    sccb_write_master #(.CLK_DIV(DIV1)) dut (
        .i2c_clk  (i2c_clk),
        .reset_n  (reset_n),
        .start    (start),
        .dev_addr (dev_addr),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .scl      (scl),
        .sda_oe   (sda_oe),
        .sda_in   (sda_in)
    );

    sccb_write_master #(.CLK_DIV(DIV2)) dut2 (
        .i2c_clk  (i2c_clk),
        .reset_n  (reset_n),
        .start    (start2),
        .dev_addr (dev_addr),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .busy     (busy2),
        .done     (done2),
        .ack_err  (ack_err2),
        .scl      (scl2),
        .sda_oe   (sda_oe2),
        .sda_in   (sda_in2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic fail_now(input string tag);
        n_checks++;
        $error("FAIL %s: got event missing expected event present", tag);
    endtask

    // Bus monitor / scoreboard consumer
    always @(negedge i2c_clk) begin
        if (!reset_n) begin
            mon_nbits = 0;
            busy_len  = 0;
            bitbuf    = '0;
        end else begin
            if (scl && prev_scl && sda_oe && !prev_oe) begin
                starts_seen++;
                mon_nbits = 0;
            end
            if (scl && prev_scl && !sda_oe && prev_oe) stops_seen++;
            if (scl && !prev_scl) begin
                bitbuf = {bitbuf[7:0], ~sda_oe};
                mon_nbits++;
                if (mon_nbits % 9 == 0) begin
                    if (exp_bytes.size() == 0) fail_now("unexpected_byte");
                    else chk("byte", {24'h0, bitbuf[8:1]}, {24'h0, exp_bytes.pop_front()});
                end
            end
            if (busy) begin
                busy_len++;
            end else if (prev_busy) begin
                chk("busy_len", busy_len, EXP_BUSY1);
                chk("done_after_busy", {31'h0, done}, 32'h1);
                busy_len = 0;
            end
            if (done) begin
                dones_seen++;
                chk("done_1cycle", {31'h0, prev_done}, 32'h0);
                if (exp_ack.size() == 0) fail_now("unexpected_done");
                else chk("ack_err", {31'h0, ack_err}, {31'h0, exp_ack.pop_front()});
            end
        end
        prev_scl  = scl;
        prev_oe   = sda_oe;
        prev_busy = busy;
        prev_done = done;
    end

    task automatic push_exp(input logic [7:0] d, input logic [7:0] r, input logic [7:0] x,
                            input logic ack);
        exp_bytes.push_back(d);
        exp_bytes.push_back(r);
        exp_bytes.push_back(x);
        exp_ack.push_back(ack);
    endtask

    task automatic go(input logic [7:0] d, input logic [7:0] r, input logic [7:0] x,
                      input logic ack);
        @(negedge i2c_clk);
        dev_addr = d; reg_addr = r; reg_data = x;
        start = 1'b1;
        push_exp(d, r, x, ack);
        @(negedge i2c_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        bool_seen: begin
            for (int i = 0; i < max_cycles; i++) begin
                @(negedge i2c_clk);
                #1;
                if (done) disable bool_seen;
            end
            fail_now("timeout_done");
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_scl"},     {31'h0, scl},     32'h1);
        chk({tag, "_sda_oe"},  {31'h0, sda_oe},  32'h0);
        chk({tag, "_busy"},    {31'h0, busy},    32'h0);
        chk({tag, "_done"},    {31'h0, done},    32'h0);
        chk({tag, "_ack_err"}, {31'h0, ack_err}, 32'h0);
    endtask

    initial begin
        int d0;
        int len;
        int r1;
        int r2;
        logic p_scl2;
        logic hit;

        // 1. reset
        repeat (3) @(negedge i2c_clk);
        check_idle("in_reset");
        reset_n = 1'b1;
        repeat (2) @(negedge i2c_clk);
        #1;
        check_idle("after_reset");

        // 2. basic write with clean acks
        starts_seen = 0; stops_seen = 0;
        go(8'h42, 8'h12, 8'h80, 1'b0);
        wait_done(EXP_BUSY1 + 20);
        chk("start_cond", starts_seen, 1);
        chk("stop_cond",  stops_seen, 1);

        // 3. NACK in the second slot, then a clean transaction
        nack_second = 1'b1;
        go(8'h42, 8'h3A, 8'h55, 1'b1);
        wait_done(EXP_BUSY1 + 20);
        nack_second = 1'b0;
        go(8'h42, 8'hC3, 8'h0F, 1'b0);
        wait_done(EXP_BUSY1 + 20);

        // 4a. start during busy is dropped
        d0 = dones_seen;
        go(8'h42, 8'h6B, 8'hA5, 1'b0);
        repeat (100) @(negedge i2c_clk);
        dev_addr = 8'h99; reg_addr = 8'h77; reg_data = 8'h66;
        start = 1'b1;
        @(negedge i2c_clk);
        start = 1'b0;
        wait_done(EXP_BUSY1 + 20);
        repeat (400) @(negedge i2c_clk);
        #1;
        chk("ignored_start_dones", dones_seen - d0, 1);
        chk("ignored_start_busy", {31'h0, busy}, 32'h0);

        // 4b. start held high: back-to-back transactions
        @(negedge i2c_clk);
        dev_addr = 8'h42; reg_addr = 8'h01; reg_data = 8'hFE;
        start = 1'b1;
        push_exp(8'h42, 8'h01, 8'hFE, 1'b0);
        @(negedge i2c_clk);
        dev_addr = 8'h43; reg_addr = 8'h5A; reg_data = 8'h3C;
        push_exp(8'h43, 8'h5A, 8'h3C, 1'b0);
        wait_done(EXP_BUSY1 + 20);
        chk("b2b_busy_in_done", {31'h0, busy}, 32'h0);
        @(negedge i2c_clk);
        #1;
        chk("b2b_busy_rose", {31'h0, busy}, 32'h1);
        chk("b2b_done_fell", {31'h0, done}, 32'h0);
        start = 1'b0;
        wait_done(EXP_BUSY1 + 20);

        // 5. reset mid reg_addr
        go(8'h42, 8'hF0, 8'h33, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < EXP_BUSY1 && !hit; i++) begin
            @(negedge i2c_clk);
            #1;
            if (mon_nbits == 13) hit = 1'b1;
        end
        if (!hit) fail_now("timeout_mid_byte");
        reset_n = 1'b0;
        #1;
        check_idle("async_reset");
        exp_bytes.delete();
        exp_ack.delete();
        repeat (3) @(negedge i2c_clk);
        reset_n = 1'b1;
        d0 = dones_seen;
        go(8'h42, 8'h11, 8'h01, 1'b0);
        wait_done(EXP_BUSY1 + 20);
        chk("post_reset_done", dones_seen - d0, 1);

        // 6. CLK_DIV=2 instance
        @(negedge i2c_clk);
        start2 = 1'b1;
        @(negedge i2c_clk);
        start2 = 1'b0;
        len = 0; r1 = -1; r2 = -1;
        p_scl2 = scl2;
        for (int i = 0; i < EXP_BUSY2 + 50 && busy2; i++) begin
            if (scl2 && !p_scl2) begin
                if (r1 < 0) r1 = len;
                else if (r2 < 0) r2 = len;
            end
            p_scl2 = scl2;
            len++;
            @(negedge i2c_clk);
        end
        chk("div2_busy_len", len, EXP_BUSY2);
        chk("div2_scl_period", r2 - r1, 8);
        chk("div2_done", {31'h0, done2}, 32'h1);

        chk("queue_bytes_empty", exp_bytes.size(), 0);
        chk("queue_ack_empty", exp_ack.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
